// File: rtl/sdram_init_ctrl_pkg.sv
// Shared SDRAM definitions used by the init sequencer and the main controller.
// Holds the command encodings {CS_N,RAS_N,CAS_N,WE_N}, the default address
// width, the mode register word, the default init timing figures (in 100 MHz
// clock cycles) and the init sequencer state type.
package sdram_params;

   localparam int ASIZE_DEF = 12;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   // Burst write, CAS latency 3, sequential, full-page burst.
   localparam logic [11:0] MODE_VALUE_DEF = 12'h037;

   localparam int INIT_WAIT_DEF = 20000;  // 200 us power-up delay
   localparam int TRP_CYC_DEF   = 2;
   localparam int TRFC_CYC_DEF  = 7;
   localparam int TMRD_CYC_DEF  = 2;
   localparam int REF_COUNT_DEF = 8;

   typedef enum logic [2:0] {
      ST_WAIT,
      ST_PRE,
      ST_TRP,
      ST_REF,
      ST_TRFC,
      ST_LMR,
      ST_TMRD,
      ST_DONE
   } init_state_t;

   function automatic int max2(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sdram_init_ctrl.sv
// SDRAM power-up initialisation sequencer.
// After reset: NOP for INIT_WAIT cycles, PRECHARGE ALL, TRP_CYC NOPs,
// REF_COUNT x (AUTO REFRESH + TRFC_CYC NOPs), LOAD MODE, TMRD_CYC NOPs,
// then init_done rises and stays high until the next reset.
// Ports:
//   CLK        controller clock (SDRAM is clocked on ~CLK)
//   RST        synchronous active-high reset
//   command    {CS_N,RAS_N,CAS_N,WE_N}, registered
//   saddr      SDRAM address bus, registered
//   init_done  high once the sequence is complete, registered
module sdram_init_ctrl
   import sdram_params::*;
#(
   parameter int                 ASIZE      = ASIZE_DEF,
   parameter int                 INIT_WAIT  = INIT_WAIT_DEF,
   parameter int                 TRP_CYC    = TRP_CYC_DEF,
   parameter int                 TRFC_CYC   = TRFC_CYC_DEF,
   parameter int                 TMRD_CYC   = TMRD_CYC_DEF,
   parameter int                 REF_COUNT  = REF_COUNT_DEF,
   parameter logic [ASIZE-1:0]   MODE_VALUE = ASIZE'(MODE_VALUE_DEF)
) (
   input  logic             CLK,
   input  logic             RST,
   output logic [3:0]       command,
   output logic [ASIZE-1:0] saddr,
   output logic             init_done
);

   // One counter serves the power-up wait and every tXX gap; it is sized for
   // the largest of them so WAIT can never wrap.
   localparam int CW = $clog2(max2(max2(INIT_WAIT, TRFC_CYC), max2(TRP_CYC, TMRD_CYC)) + 1);
   localparam int RW = $clog2(REF_COUNT + 1);

   localparam logic [CW-1:0] WAIT_END = CW'(INIT_WAIT);
   localparam logic [CW-1:0] TRP_END  = CW'(TRP_CYC);
   localparam logic [CW-1:0] TRFC_END = CW'(TRFC_CYC);
   localparam logic [CW-1:0] TMRD_END = CW'(TMRD_CYC);
   localparam logic [RW-1:0] REF_END  = RW'(REF_COUNT);

   // A10 high selects all banks for PRECHARGE.
   localparam logic [ASIZE-1:0] PRE_ALL = ASIZE'(1) << 10;

   init_state_t      state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [RW-1:0]    ref_cnt, ref_cnt_nxt;
   logic [3:0]       cmd_nxt;
   logic [ASIZE-1:0] addr_nxt;
   logic             done_nxt;

   always_ff @(posedge CLK) begin
      if (RST) begin
         state     <= ST_WAIT;
         cnt       <= '0;
         ref_cnt   <= '0;
         command   <= CMD_NOP;
         saddr     <= '0;
         init_done <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         ref_cnt   <= ref_cnt_nxt;
         command   <= cmd_nxt;
         saddr     <= addr_nxt;
         init_done <= done_nxt;
      end
   end

   // Outputs are computed for the state being entered, so a command appears
   // on the bus in the same cycle its state becomes current. Leaving a
   // command state loads cnt with 1; the gap state exits when cnt reaches
   // the gap length, giving exactly that many NOP cycles.
   always_comb begin
      state_nxt   = state;
      cnt_nxt     = cnt;
      ref_cnt_nxt = ref_cnt;
      cmd_nxt     = CMD_NOP;
      addr_nxt    = '0;
      done_nxt    = 1'b0;
      case (state)
         ST_WAIT: begin
            if (cnt == WAIT_END) begin
               state_nxt = ST_PRE;
               cmd_nxt   = CMD_PRE;
               addr_nxt  = PRE_ALL;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_PRE: begin
            state_nxt = ST_TRP;
            cnt_nxt   = CW'(1);
         end
         ST_TRP: begin
            if (cnt == TRP_END) begin
               state_nxt   = ST_REF;
               cmd_nxt     = CMD_REF;
               ref_cnt_nxt = ref_cnt + 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_REF: begin
            state_nxt = ST_TRFC;
            cnt_nxt   = CW'(1);
         end
         ST_TRFC: begin
            if (cnt == TRFC_END) begin
               // ref_cnt counts refreshes already issued.
               if (ref_cnt == REF_END) begin
                  state_nxt = ST_LMR;
                  cmd_nxt   = CMD_LMR;
                  addr_nxt  = MODE_VALUE;
               end else begin
                  state_nxt   = ST_REF;
                  cmd_nxt     = CMD_REF;
                  ref_cnt_nxt = ref_cnt + 1'b1;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_LMR: begin
            state_nxt = ST_TMRD;
            cnt_nxt   = CW'(1);
         end
         ST_TMRD: begin
            if (cnt == TMRD_END) begin
               state_nxt = ST_DONE;
               done_nxt  = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         ST_DONE: begin
            done_nxt = 1'b1;
         end
         default: begin
            state_nxt = ST_WAIT;
            cnt_nxt   = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Bench for sdram_init_ctrl: a cycle-indexed model of the init timeline is
// compared with the DUT outputs on every negative edge, plus literal checks
// of where PRECHARGE, the refreshes, LOAD MODE and init_done actually landed.
module tb_sdram_init_ctrl;

   localparam int IW   = 20000;
   localparam int TRP  = 2;
   localparam int TRFC = 7;
   localparam int TMRD = 2;
   localparam int NREF = 8;

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [3:0]  command;
   logic [11:0] saddr;
   logic        init_done;

   int checks = 0;
   int errors = 0;

   // n: index of the last rising edge counted from reset release; -1 while
   // reset was sampled, -2 before any edge.
   int n = -2;

   // Observations of the current run, gathered by the monitor.
   int          pre_cycle;
   int          lmr_cycle;
   int          done_cycle;
   int          ref_seen;
   logic [11:0] lmr_addr;

   sdram_init_ctrl dut (
      .CLK       (CLK),
      .RST       (RST),
      .command   (command),
      .saddr     (saddr),
      .init_done (init_done)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (RST) n <= -1;
      else     n <= n + 1;
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, n);
      end
   endtask

   // Timeline model: expected {command, saddr, init_done} at cycle c.
   function automatic logic [16:0] model(input int c);
      int first_ref, lmr_at, done_at;
      first_ref = IW + 1 + TRP;
      lmr_at    = first_ref + NREF * (TRFC + 1);
      done_at   = lmr_at + 1 + TMRD;
      if (c < 0)         return {4'b0111, 12'h000, 1'b0};
      if (c == IW)       return {4'b0010, 12'h400, 1'b0};
      if (c == lmr_at)   return {4'b0000, 12'h037, 1'b0};
      if (c >= done_at)  return {4'b0111, 12'h000, 1'b1};
      if (c >= first_ref && c < lmr_at && ((c - first_ref) % (TRFC + 1)) == 0)
         return {4'b0001, 12'h000, 1'b0};
      return {4'b0111, 12'h000, 1'b0};
   endfunction

   // Per-cycle compare and event recording.
   always @(negedge CLK) begin
      if (n >= -1) begin
         logic [16:0] e;
         e = model(n);
         check("command",   int'(command),   int'(e[16:13]));
         check("saddr",     int'(saddr),     int'(e[12:1]));
         check("init_done", int'(init_done), int'(e[0]));
         if (n == -1) begin
            pre_cycle  = -1;
            lmr_cycle  = -1;
            done_cycle = -1;
            ref_seen   = 0;
            lmr_addr   = '0;
         end else begin
            if (command == 4'b0010 && pre_cycle < 0) pre_cycle = n;
            if (command == 4'b0001) ref_seen++;
            if (command == 4'b0000) begin
               lmr_cycle = n;
               lmr_addr  = saddr;
            end
            if (init_done && done_cycle < 0) done_cycle = n;
         end
      end
   end

   initial begin
      logic [16:0] m;
      // Pin the model to hand-computed timeline points.
      m = model(19999); check("model_19999", int'(m[16:13]), 4'b0111);
      m = model(20000); check("model_pre",   int'(m[12:1]),  12'h400);
      m = model(20003); check("model_ref1",  int'(m[16:13]), 4'b0001);
      m = model(20059); check("model_ref8",  int'(m[16:13]), 4'b0001);
      m = model(20060); check("model_20060", int'(m[16:13]), 4'b0111);
      m = model(20067); check("model_lmr",   int'(m[12:1]),  12'h037);
      m = model(20069); check("model_20069", int'(m[0]),     0);
      m = model(20070); check("model_done",  int'(m[0]),     1);

      // Reset held 20 cycles, then a full sequence plus 2000 cycles of DONE.
      RST = 1'b1;
      repeat (20) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (20071 + 2000) @(posedge CLK);
      @(negedge CLK);
      check("run1_pre_cycle",  pre_cycle,       20000);
      check("run1_ref_count",  ref_seen,        8);
      check("run1_lmr_cycle",  lmr_cycle,       20067);
      check("run1_lmr_addr",   int'(lmr_addr),  12'h037);
      check("run1_done_cycle", done_cycle,      20070);

      // Fresh run, reset asserted mid-refresh at cycle 20040 for 2 cycles.
      #1 RST = 1'b1;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (20040) @(posedge CLK);
      @(negedge CLK);
      check("run2_refs_before_rst", ref_seen, 5);
      RST = 1'b1;
      repeat (2) @(posedge CLK);
      #1 RST = 1'b0;
      repeat (20100) @(posedge CLK);
      @(negedge CLK);
      check("run2_pre_cycle",  pre_cycle,  20000);
      check("run2_ref_count",  ref_seen,   8);
      check("run2_done_level", int'(init_done), 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
